gate_send: RTL and testbench

- Transmit-side gate of the DTU routing path; the send-end counterpart of the receive gate.
- Accepts send requests from user logic, each naming a destination port and a sender UL id.
- Checks each request against a host-programmed capability table and emits a stamped 8-bit route word on a valid/ready channel.
- Rejects unauthorised requests with a deny pulse and counts them for host readback.

---
 rtl/gate_send_if.sv | 20 ++
 rtl/gate_send.sv | 133 +++++++++++++
 tb/tb_gate_send.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/gate_send_if.sv
// rtl/gate_send_if.sv - request and route-word handshake channels of the send gate
interface gate_send_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_port;
    logic [2:0] req_ul_id;
    logic [7:0] route_out;
    logic       route_valid;
    logic       route_ready;

    modport master (
        output req_valid, req_port, req_ul_id, route_ready,
        input  req_ready, route_out, route_valid
    );

    modport slave (
        input  req_valid, req_port, req_ul_id, route_ready,
        output req_ready, route_out, route_valid
    );
endinterface

// File: rtl/gate_send.sv
// rtl/gate_send.sv - send-side capability gate; optional per-port route sequence under GATE_SEND_SEQ_EN
module gate_send #(
    parameter int N_DESTS = 4,
    parameter int CNT_W   = 16
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             host_cap_valid,
    input  logic [7:0]       host_route_cap_in,
    gate_send_if.slave       gs,
    output logic             deny_out,
    output logic [CNT_W-1:0] deny_cnt
);
    localparam logic [2:0] NDEST3 = 3'(N_DESTS);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_SEND, S_DENY} state_t;

    state_t     state;
    logic [3:0] cap_en;
    logic [2:0] cap_ul [4];
    logic [1:0] cur_port;
    logic [2:0] cur_ul;
    logic       pass_q;
    logic       route_valid_q;
    logic [7:0] route_out_q;
    logic [2:0] seq_field;

    logic [1:0] host_port;
    logic       host_wr;
    logic       hs_req;
    logic       hs_route;
    logic       lookup_ok;
    logic       unused_cap_bits;

    assign host_port       = host_route_cap_in[1:0];
    assign host_wr         = host_cap_valid && ({1'b0, host_port} < NDEST3);
    assign unused_cap_bits = ^host_route_cap_in[6:5];

    assign gs.req_ready   = (state == S_IDLE) && !areset;
    assign gs.route_valid = route_valid_q;
    assign gs.route_out   = route_out_q;

    assign hs_req   = gs.req_valid && gs.req_ready;
    assign hs_route = (state == S_SEND) && gs.route_ready;

    // Decided at the handshake edge so a host write on that same edge cannot sway it.
    assign lookup_ok = ({1'b0, gs.req_port} < NDEST3) && cap_en[gs.req_port]
                       && (cap_ul[gs.req_port] == gs.req_ul_id);

    always_ff @(posedge aclk) begin
        if (areset) begin
            cap_en <= '0;
        end else if (host_wr) begin
            cap_en[host_port] <= host_route_cap_in[7];
        end
    end

    always_ff @(posedge aclk) begin
        if (host_wr) begin
            cap_ul[host_port] <= host_route_cap_in[4:2];
        end
    end

`ifdef GATE_SEND_SEQ_EN
    logic [2:0] seq_cnt [4];

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int p = 0; p < 4; p++) seq_cnt[p] <= 3'd0;
        end else begin
            for (int p = 0; p < 4; p++) begin
                if (host_wr && host_port == 2'(p)) begin
                    seq_cnt[p] <= 3'd0;
                end else if (hs_route && cur_port == 2'(p)) begin
                    seq_cnt[p] <= seq_cnt[p] + 3'd1;
                end
            end
        end
    end

    assign seq_field = seq_cnt[cur_port];
`else
    assign seq_field = 3'b000;
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            state         <= S_IDLE;
            cur_port      <= 2'd0;
            cur_ul        <= 3'd0;
            pass_q        <= 1'b0;
            route_valid_q <= 1'b0;
            route_out_q   <= 8'd0;
            deny_out      <= 1'b0;
            deny_cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (hs_req) begin
                        cur_port <= gs.req_port;
                        cur_ul   <= gs.req_ul_id;
                        pass_q   <= lookup_ok;
                        state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (pass_q) begin
                        route_valid_q <= 1'b1;
                        route_out_q   <= {seq_field, cur_ul, cur_port};
                        state         <= S_SEND;
                    end else begin
                        deny_out <= 1'b1;
                        if (deny_cnt != {CNT_W{1'b1}}) begin
                            deny_cnt <= deny_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                        state <= S_DENY;
                    end
                end
                S_SEND: begin
                    if (gs.route_ready) begin
                        route_valid_q <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                S_DENY: begin
                    deny_out <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gate_send.sv
// tb/tb_gate_send.sv - directed and randomized checks of gate_send against a table/counter model
module tb_gate_send;
    localparam int ND = 2;

    logic        aclk = 1'b0;
    logic        areset;
    logic        host_cap_valid;
    logic [7:0]  host_data;
    logic        deny_out;
    logic [15:0] deny_cnt;

    gate_send_if bus ();

    gate_send #(.N_DESTS(ND), .CNT_W(16)) dut (
        .aclk              (aclk),
        .areset            (areset),
        .host_cap_valid    (host_cap_valid),
        .host_route_cap_in (host_data),
        .gs                (bus),
        .deny_out          (deny_out),
        .deny_cnt          (deny_cnt)
    );

    always #5 aclk = ~aclk;

    int vectors = 0;
    int miscompares = 0;

    bit       m_en  [4];
    bit [2:0] m_ul  [4];
    bit [2:0] m_seq [4];
    int       m_deny;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_en[i]  = 1'b0;
            m_ul[i]  = 3'd0;
            m_seq[i] = 3'd0;
        end
        m_deny = 0;
    endtask

    task automatic model_write(input logic [7:0] d);
        int p;
        p = int'(d[1:0]);
        if (p < ND) begin
            m_en[p]  = d[7];
            m_ul[p]  = d[4:2];
            m_seq[p] = 3'd0;
        end
    endtask

    function automatic logic [2:0] exp_seq(input int p);
`ifdef GATE_SEND_SEQ_EN
        return m_seq[p];
`else
        return 3'd0;
`endif
    endfunction

    task automatic host_write(input logic [7:0] d);
        host_cap_valid = 1'b1;
        host_data      = d;
        tick();
        host_cap_valid = 1'b0;
        model_write(d);
    endtask

    task automatic request(input logic [1:0] port, input logic [2:0] ul, input int hold,
                           input bit wr, input logic [7:0] wdata);
        bit         pass;
        logic [7:0] word;
        check("idle_req_ready", 32'(bus.req_ready), 32'd1);
        pass = (int'(port) < ND) && m_en[port] && (m_ul[port] == ul);
        bus.req_valid = 1'b1;
        bus.req_port  = port;
        bus.req_ul_id = ul;
        if (wr) begin
            host_cap_valid = 1'b1;
            host_data      = wdata;
        end
        tick();
        bus.req_valid  = 1'b0;
        host_cap_valid = 1'b0;
        if (wr) model_write(wdata);
        check("check_req_ready", 32'(bus.req_ready), 32'd0);
        check("check_route_valid", 32'(bus.route_valid), 32'd0);
        check("check_deny_out", 32'(deny_out), 32'd0);
        bus.route_ready = (hold == 0);
        tick();
        if (pass) begin
            word = {exp_seq(int'(port)), ul, port};
            check("send_route_valid", 32'(bus.route_valid), 32'd1);
            check("send_route_out", 32'(bus.route_out), 32'(word));
            check("send_deny_out", 32'(deny_out), 32'd0);
            for (int i = 0; i < hold; i++) begin
                tick();
                check("hold_route_valid", 32'(bus.route_valid), 32'd1);
                check("hold_route_out", 32'(bus.route_out), 32'(word));
                check("hold_req_ready", 32'(bus.req_ready), 32'd0);
            end
            bus.route_ready = 1'b1;
            tick();
            bus.route_ready = 1'b0;
            m_seq[port] = m_seq[port] + 3'd1;
            check("post_send_route_valid", 32'(bus.route_valid), 32'd0);
            check("post_send_req_ready", 32'(bus.req_ready), 32'd1);
            check("post_send_deny_cnt", 32'(deny_cnt), 32'(m_deny));
        end else begin
            if (m_deny < 65535) m_deny++;
            check("deny_pulse", 32'(deny_out), 32'd1);
            check("deny_route_valid", 32'(bus.route_valid), 32'd0);
            check("deny_cnt", 32'(deny_cnt), 32'(m_deny));
            bus.route_ready = 1'b0;
            tick();
            check("deny_pulse_end", 32'(deny_out), 32'd0);
            check("post_deny_req_ready", 32'(bus.req_ready), 32'd1);
            check("post_deny_route_valid", 32'(bus.route_valid), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] w;
        logic [1:0] p;
        logic [2:0] u;

        areset          = 1'b1;
        host_cap_valid  = 1'b0;
        host_data       = 8'd0;
        bus.req_valid   = 1'b0;
        bus.req_port    = 2'd0;
        bus.req_ul_id   = 3'd0;
        bus.route_ready = 1'b0;
        model_clear();
        tick();
        tick();
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_route_valid", 32'(bus.route_valid), 32'd0);
        check("rst_route_out", 32'(bus.route_out), 32'd0);
        check("rst_deny_out", 32'(deny_out), 32'd0);
        check("rst_deny_cnt", 32'(deny_cnt), 32'd0);
        areset = 1'b0;
        tick();
        check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

        // Grant, wrong UL, unprogrammed and out-of-range ports
        host_write(8'h95);
        request(2'd1, 3'd5, 0, 1'b0, 8'h00);
        request(2'd1, 3'd3, 0, 1'b0, 8'h00);
        request(2'd0, 3'd0, 0, 1'b0, 8'h00);
        request(2'd3, 3'd0, 0, 1'b0, 8'h00);
        host_write(8'h83);
        request(2'd3, 3'd0, 0, 1'b0, 8'h00);

        // Backpressure, then revoke landing on the handshake edge
        request(2'd1, 3'd5, 5, 1'b0, 8'h00);
        request(2'd1, 3'd5, 0, 1'b1, 8'h15);
        request(2'd1, 3'd5, 0, 1'b0, 8'h00);

        // Sequence run with an interleaved deny, then capability rewrite
        host_write(8'h95);
        for (int i = 0; i < 9; i++) begin
            if (i == 4) request(2'd1, 3'd2, 0, 1'b0, 8'h00);
            request(2'd1, 3'd5, i % 2, 1'b0, 8'h00);
        end
        host_write(8'h95);
        request(2'd1, 3'd5, 0, 1'b0, 8'h00);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                w = 8'($urandom);
                w[1:0] = 2'($urandom_range(0, 3));
                host_write(w);
            end
            if ($urandom_range(0, 4) == 0) begin
                bus.route_ready = 1'b1;
                tick();
                bus.route_ready = 1'b0;
                check("idle_route_ready_ignored", 32'(bus.route_valid), 32'd0);
            end
            p = 2'($urandom_range(0, 3));
            u = ($urandom_range(0, 1) == 1) ? m_ul[p] : 3'($urandom);
            request(p, u, int'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0), 8'($urandom));
        end

        // Reset while a granted word is being presented
        host_write(8'h95);
        bus.req_valid = 1'b1;
        bus.req_port  = 2'd1;
        bus.req_ul_id = 3'd5;
        tick();
        bus.req_valid   = 1'b0;
        bus.route_ready = 1'b0;
        tick();
        tick();
        check("pre_rst_route_valid", 32'(bus.route_valid), 32'd1);
        check("pre_rst_deny_cnt", 32'(deny_cnt), 32'(m_deny));
        areset = 1'b1;
        tick();
        check("rst_send_route_valid", 32'(bus.route_valid), 32'd0);
        check("rst_send_deny_cnt", 32'(deny_cnt), 32'd0);
        check("rst_send_req_ready", 32'(bus.req_ready), 32'd0);
        areset = 1'b0;
        model_clear();
        tick();
        check("rst_send_recover_ready", 32'(bus.req_ready), 32'd1);
        request(2'd1, 3'd5, 0, 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
